// File: rtl/ecc_arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ecc_arith_pkg                                                |
// | Description : Shared FSM encodings, P-384 modulus and counter-width helper |
// |               for the chunk-serial modular adder/subtractor.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ecc_arith_pkg;

  // FSM state encoding, explicit 2-bit width
  typedef logic [1:0] state_t;
  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_run  = 2'd1;
  localparam state_t c_st_done = 2'd2;

  // NIST P-384 field prime: 2^384 - 2^128 - 2^96 + 2^32 - 1
  localparam logic [383:0] c_p384 =
    384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

  // Chunk-counter width; never below one bit so NUM_ADDS=1 still has a legal vector
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_mod_seq_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sub_mod_seq_adder                                        |
// | Description : N-bit adder with carry-in and carry-out; one chunk of a      |
// |               carry chain.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_sub_mod_seq_adder #(
  parameter int N = 96
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Zero-extend everything to N+1 bits so the carry-out lands in the top bit
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/add_sub_mod_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sub_mod_seq                                              |
// | Description : Multi-cycle chunk-serial modular add/sub over a prime field. |
// |               Chain 0 forms a+b or a-b, chain 1 forms that result minus    |
// |               (add) or plus (sub) the prime; carries of both chains are    |
// |               registered between chunks and pick the final result.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_sub_mod_seq
  import ecc_arith_pkg::*;
#(
  parameter int                  REG_SIZE = 384,
  parameter logic [REG_SIZE-1:0] PRIME    = c_p384,
  parameter int                  NUM_ADDS = 4,
  parameter int                  BASE_SZ  = 96
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                sub_i,
  input  logic                red_i,
  input  logic [REG_SIZE-1:0] opa_i,
  input  logic [REG_SIZE-1:0] opb_i,
  output logic [REG_SIZE-1:0] res_o,
  output logic                busy_o,
  output logic                ready_o
);

  localparam int c_cnt_w = cnt_w(NUM_ADDS);

  // The chunking only works when the chunks tile the operand exactly
  generate
    if (REG_SIZE != NUM_ADDS * BASE_SZ) begin : g_size_check
      $error("add_sub_mod_seq: REG_SIZE must equal NUM_ADDS*BASE_SZ");
    end
  endgenerate

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [REG_SIZE-1:0]  r_a;
  logic [REG_SIZE-1:0]  r_b;
  logic                 r_sub;
  logic                 r_red;
  logic                 r_c0;
  logic                 r_c1;
  logic [REG_SIZE-1:0]  r_r0;
  logic [REG_SIZE-1:0]  r_r1;
  logic [REG_SIZE-1:0]  r_res;
  logic                 r_ready;

  logic                 w_accept;
  logic                 w_last;
  logic [31:0]          w_base;
  logic [BASE_SZ-1:0]   w_a_k;
  logic [BASE_SZ-1:0]   w_b_k;
  logic [BASE_SZ-1:0]   w_p_k;
  logic [BASE_SZ-1:0]   w_s0;
  logic [BASE_SZ-1:0]   w_s1;
  logic                 w_co0;
  logic                 w_co1;
  logic [REG_SIZE-1:0]  w_res_sel;

  // A new operation is only taken when no chunk work is in flight
  assign w_accept = start_i && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_last   = (r_cnt == c_cnt_w'(NUM_ADDS - 1));
  assign w_base   = 32'(r_cnt) * 32'(BASE_SZ);

  // Current chunk operands; subtraction uses a + ~b + 1 and the +1 comes from the seeded carry
  assign w_a_k = r_a[w_base +: BASE_SZ];
  assign w_b_k = r_sub ? ~r_b[w_base +: BASE_SZ] : r_b[w_base +: BASE_SZ];
  assign w_p_k = r_sub ? PRIME[w_base +: BASE_SZ] : ~PRIME[w_base +: BASE_SZ];

  add_sub_mod_seq_adder #(.N(BASE_SZ)) u_chain0 (
    .a    (w_a_k),
    .b    (w_b_k),
    .cin  (r_c0),
    .sum  (w_s0),
    .cout (w_co0)
  );

  add_sub_mod_seq_adder #(.N(BASE_SZ)) u_chain1 (
    .a    (w_s0),
    .b    (w_p_k),
    .cin  (r_c1),
    .sum  (w_s1),
    .cout (w_co1)
  );

  // Final selection from the two chains and their last carries
  always_comb begin
    w_res_sel = r_r0;
    if (r_red) begin
      if (r_sub) begin
        // no borrow out of a-b means r0 is already in range; otherwise add p back
        w_res_sel = r_c0 ? r_r0 : r_r1;
      end else begin
        // overflow past 2^REG_SIZE or no borrow from r0-p means the sum reached p
        w_res_sel = (r_c0 | r_c1) ? r_r1 : r_r0;
      end
    end
  end

  // Control FSM: IDLE -> RUN for NUM_ADDS chunks -> DONE for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (start_i) r_state <= c_st_run;
        c_st_run:  if (w_last)  r_state <= c_st_done;
        c_st_done: r_state <= start_i ? c_st_run : c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  // Operand capture on accept, then one chunk of both chains per RUN cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sub <= 1'b0;
      r_red <= 1'b0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
      r_r0  <= '0;
      r_r1  <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_a   <= opa_i;
      r_b   <= opb_i;
      r_sub <= sub_i;
      r_red <= red_i;
      r_c0  <= sub_i;
      r_c1  <= ~sub_i;
    end else if (r_state == c_st_run) begin
      r_r0[w_base +: BASE_SZ] <= w_s0;
      r_r1[w_base +: BASE_SZ] <= w_s1;
      r_c0  <= w_co0;
      r_c1  <= w_co1;
      r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  // Result register and ready pulse, loaded only while in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (r_state == c_st_done);
      if (r_state == c_st_done) begin
        r_res <= w_res_sel;
      end
    end
  end

  assign res_o   = r_res;
  assign ready_o = r_ready;
  assign busy_o  = (r_state == c_st_run);

endmodule
`default_nettype wire

// File: tb/tb_add_sub_mod_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_add_sub_mod_seq                                           |
// | Description : Directed and random checks of add_sub_mod_seq with the      |
// |               4-chunk default and a single-chunk (NUM_ADDS=1) instance.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_add_sub_mod_seq;

  localparam logic [383:0] P =
    384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start4 = 1'b0;
  logic         start1 = 1'b0;
  logic         sub_i = 1'b0;
  logic         red_i = 1'b1;
  logic [383:0] opa = '0;
  logic [383:0] opb = '0;
  logic [383:0] res4, res1;
  logic         busy4, busy1, rdy4, rdy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_sub_mod_seq dut4 (
    .clk(clk), .reset_n(reset_n), .start_i(start4), .sub_i(sub_i), .red_i(red_i),
    .opa_i(opa), .opb_i(opb), .res_o(res4), .busy_o(busy4), .ready_o(rdy4)
  );

  add_sub_mod_seq #(.NUM_ADDS(1), .BASE_SZ(384)) dut1 (
    .clk(clk), .reset_n(reset_n), .start_i(start1), .sub_i(sub_i), .red_i(red_i),
    .opa_i(opa), .opb_i(opb), .res_o(res1), .busy_o(busy1), .ready_o(rdy1)
  );

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [383:0] rand_fe();
    logic [383:0] v;
    v = rand384();
    if (v >= P) v = v - P;
    return v;
  endfunction

  function automatic logic [383:0] ref_op(input logic s, input logic r,
                                          input logic [383:0] a, input logic [383:0] b);
    logic [384:0] t;
    if (!s) begin
      t = {1'b0, a} + {1'b0, b};
      if (r && (t >= {1'b0, P})) t = t - {1'b0, P};
    end else begin
      t = {1'b0, a} - {1'b0, b};
      if (r && (a < b)) t = t + {1'b0, P};
    end
    return t[383:0];
  endfunction

  // Launch one op on the chosen instance; report result, cycles to ready (-1 on timeout) and busy cycles
  task automatic run_op(input int which, input logic s, input logic r,
                        input logic [383:0] a, input logic [383:0] b,
                        output logic [383:0] res, output int lat, output int busy_n);
    @(negedge clk);
    sub_i = s; red_i = r; opa = a; opb = b;
    if (which == 1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    opa = rand384(); opb = rand384(); sub_i = ~s; red_i = ~r;
    lat = -1; res = '0; busy_n = 0;
    for (int c = 1; c <= 12; c++) begin
      if ((which == 1) ? busy1 : busy4) busy_n++;
      @(posedge clk); #1;
      if ((which == 1) ? rdy1 : rdy4) begin
        lat = c;
        res = (which == 1) ? res1 : res4;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({res4, busy4, rdy4} !== 386'd0) begin
      bad++; $display("FAIL reset_dut4: got res=%h busy=%b rdy=%b, want all 0", res4, busy4, rdy4);
    end
    total++;
    if ({res1, busy1, rdy1} !== 386'd0) begin
      bad++; $display("FAIL reset_dut1: got res=%h busy=%b rdy=%b, want all 0", res1, busy1, rdy1);
    end
  endtask

  task automatic test_add(input int which);
    logic [383:0] res;
    int lat, bn, lat_exp, bn_exp;
    lat_exp = (which == 1) ? 2 : 5;
    bn_exp  = (which == 1) ? 1 : 4;
    run_op(which, 1'b0, 1'b1, 384'd5, 384'd7, res, lat, bn);
    total++;
    if (res !== 384'd12 || lat !== lat_exp || bn !== bn_exp) begin
      bad++; $display("FAIL add_5_7[%0d]: got res=%h lat=%0d busy=%0d, want 12 lat=%0d busy=%0d",
                      which, res, lat, bn, lat_exp, bn_exp);
    end
    run_op(which, 1'b0, 1'b1, P - 384'd1, 384'd1, res, lat, bn);
    total++;
    if (res !== 384'd0 || lat !== lat_exp) begin
      bad++; $display("FAIL add_pm1_1[%0d]: got res=%h lat=%0d, want 0 lat=%0d", which, res, lat, lat_exp);
    end
    run_op(which, 1'b0, 1'b1, P - 384'd1, P - 384'd1, res, lat, bn);
    total++;
    if (res !== P - 384'd2 || lat !== lat_exp) begin
      bad++; $display("FAIL add_pm1_pm1[%0d]: got res=%h lat=%0d, want %h", which, res, lat, P - 384'd2);
    end
  endtask

  task automatic test_sub(input int which);
    logic [383:0] res;
    int lat, bn;
    run_op(which, 1'b1, 1'b1, 384'd0, 384'd1, res, lat, bn);
    total++;
    if (res !== P - 384'd1 || lat < 0) begin
      bad++; $display("FAIL sub_0_1[%0d]: got res=%h lat=%0d, want %h", which, res, lat, P - 384'd1);
    end
    run_op(which, 1'b1, 1'b1, 384'd9, 384'd4, res, lat, bn);
    total++;
    if (res !== 384'd5 || lat < 0) begin
      bad++; $display("FAIL sub_9_4[%0d]: got res=%h lat=%0d, want 5", which, res, lat);
    end
    run_op(which, 1'b1, 1'b1, 384'h1234, 384'h1234, res, lat, bn);
    total++;
    if (res !== 384'd0 || lat < 0) begin
      bad++; $display("FAIL sub_eq[%0d]: got res=%h lat=%0d, want 0", which, res, lat);
    end
  endtask

  task automatic test_raw();
    logic [383:0] res, ones;
    int lat, bn;
    ones = '1;
    run_op(4, 1'b0, 1'b0, P - 384'd1, 384'd2, res, lat, bn);
    total++;
    if (res !== P + 384'd1 || lat !== 5) begin
      bad++; $display("FAIL raw_add: got res=%h lat=%0d, want %h", res, lat, P + 384'd1);
    end
    run_op(4, 1'b1, 1'b0, 384'd0, 384'd1, res, lat, bn);
    total++;
    if (res !== ones || lat !== 5) begin
      bad++; $display("FAIL raw_sub: got res=%h lat=%0d, want all ones", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    @(negedge clk);
    sub_i = 1'b0; red_i = 1'b1; opa = 384'd1; opb = 384'd2; start4 = 1'b1;
    @(posedge clk); #1;
    opa = 384'd10; opb = 384'd20;
    repeat (4) @(posedge clk);
    #1;
    @(posedge clk); #1;
    total++;
    if (rdy4 !== 1'b1 || res4 !== 384'd3 || busy4 !== 1'b1) begin
      bad++; $display("FAIL b2b_first: got rdy=%b res=%h busy=%b, want rdy=1 res=3 busy=1", rdy4, res4, busy4);
    end
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (res4 !== 384'd3) begin
      bad++; $display("FAIL b2b_hold: got res=%h, want 3", res4);
    end
    seen = -1;
    for (int c = 3; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rdy4) begin seen = c; break; end
    end
    total++;
    if (seen !== 5 || res4 !== 384'd30) begin
      bad++; $display("FAIL b2b_second: got res=%h at cycle %0d, want 30 at cycle 5", res4, seen);
    end
  endtask

  task automatic test_start_mid_run();
    int n_rdy, first;
    logic [383:0] res;
    @(negedge clk);
    sub_i = 1'b0; red_i = 1'b1; opa = 384'd100; opb = 384'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1; opa = 384'd7; opb = 384'd7;
    @(posedge clk); #1;
    start4 = 1'b0;
    n_rdy = 0; first = -1; res = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (rdy4) begin
        n_rdy++;
        if (first < 0) begin first = c; res = res4; end
      end
    end
    total++;
    if (n_rdy !== 1 || first !== 3 || res !== 384'd101) begin
      bad++; $display("FAIL mid_run_start: got %0d ready at cycle %0d res=%h, want 1 at cycle 3 res=101",
                      n_rdy, first, res);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_rdy, lat, bn;
    logic [383:0] res;
    @(negedge clk);
    sub_i = 1'b0; red_i = 1'b1; opa = 384'd5; opb = 384'd6; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (res4 !== 384'd0 || busy4 !== 1'b0 || rdy4 !== 1'b0) begin
      bad++; $display("FAIL abort_reset: got res=%h busy=%b rdy=%b, want all 0", res4, busy4, rdy4);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rdy4 || busy4) n_rdy++;
    end
    total++;
    if (n_rdy !== 0) begin
      bad++; $display("FAIL abort_quiet: got %0d active cycles after reset, want 0", n_rdy);
    end
    run_op(4, 1'b0, 1'b1, 384'd5, 384'd6, res, lat, bn);
    total++;
    if (res !== 384'd11 || lat !== 5) begin
      bad++; $display("FAIL after_abort: got res=%h lat=%0d, want 11 lat=5", res, lat);
    end
  endtask

  task automatic test_random(input int which, input int n);
    logic [383:0] a, b, res, exp;
    logic s, r;
    int lat, bn, lat_exp;
    lat_exp = (which == 1) ? 2 : 5;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      a = rand_fe();
      b = rand_fe();
      if (i < 4) b = a;
      exp = ref_op(s, r, a, b);
      run_op(which, s, r, a, b, res, lat, bn);
      total++;
      if (res !== exp || lat !== lat_exp) begin
        bad++; $display("FAIL random[%0d] #%0d sub=%b red=%b: got res=%h lat=%0d, want %h", which, i, s, r, res, lat, exp);
      end
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_add(4);
    test_sub(4);
    test_raw();
    test_back_to_back();
    test_start_mid_run();
    test_reset_mid_run();
    test_add(1);
    test_sub(1);
    test_random(4, 150);
    test_random(1, 150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
